// File: rtl/seg_display_ctrl.sv
// Result-to-display sequencer: accepts one ALU result per handshake and converts it
// to packed BCD with a sequential double-dabble loop. It also selects the display mode
// and generates the digit-scan tick and digit index.
module seg_display_ctrl #(
    parameter int IND_ALU = 11,
    parameter int C_ALU   = 3,
    parameter int CNT     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic [IND_ALU-1:0] res_data,
    input  logic               res_neg,
    input  logic               res_err,
    input  logic               res_dot,
    output logic [15:0]        bcd,
    output logic [C_ALU-1:0]   disp_mode,
    output logic               disp_upd,
    output logic               scan_tick,
    output logic [1:0]         scan_sel
);

    localparam int ITW = $clog2(IND_ALU);
    localparam logic [ITW-1:0]   LAST_ITER  = ITW'(IND_ALU - 1);
    localparam logic [C_ALU-1:0] MODE_PLAIN = C_ALU'(0);
    localparam logic [C_ALU-1:0] MODE_NEG   = C_ALU'(1);
    localparam logic [C_ALU-1:0] MODE_ERR   = C_ALU'(2);
    localparam logic [C_ALU-1:0] MODE_DOT   = C_ALU'(4);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state;
    logic [IND_ALU-1:0] sr;
    logic [15:0]        acc;
    logic [15:0]        acc_adj;
    logic [ITW-1:0]     iter;
    logic               neg_q;
    logic               err_q;
    logic               dot_q;
    logic [CNT-1:0]     presc;

    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_ready <= 1'b1;
            sr        <= '0;
            acc       <= '0;
            iter      <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            dot_q     <= 1'b0;
            bcd       <= '0;
            disp_mode <= MODE_PLAIN;
            disp_upd  <= 1'b0;
        end else begin
            disp_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        neg_q     <= res_neg;
                        err_q     <= res_err;
                        dot_q     <= res_dot;
                        res_ready <= 1'b0;
                        if (res_err) begin
                            state <= DONE;
                        end else begin
                            sr    <= res_data;
                            acc   <= '0;
                            iter  <= '0;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    {acc, sr} <= {acc_adj, sr} << 1;
                    iter      <= iter + ITW'(1);
                    if (iter == LAST_ITER)
                        state <= DONE;
                end
                DONE: begin
                    state     <= IDLE;
                    res_ready <= 1'b1;
                    disp_upd  <= 1'b1;
                    // A non-zero thousands digit means the magnitude exceeds 999,
                    // which cannot be shown next to the minus sign.
                    if (err_q || (neg_q && acc[15:12] != 4'd0)) begin
                        bcd       <= '0;
                        disp_mode <= MODE_ERR;
                    end else if (neg_q) begin
                        bcd       <= {4'd0, acc[11:0]};
                        disp_mode <= MODE_NEG;
                    end else begin
                        bcd       <= acc;
                        disp_mode <= dot_q ? MODE_DOT : MODE_PLAIN;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            scan_tick <= 1'b0;
            scan_sel  <= '0;
        end else begin
            presc     <= presc + CNT'(1);
            scan_tick <= (presc == '1);
            if (scan_tick)
                scan_sel <= scan_sel + 2'd1;
        end
    end

endmodule
